seg_scan_ctrl: RTL

SEG_SCAN_CTRL -- requirements
Module: seg_scan_ctrl

---
 rtl/seg_scan_ctrl.sv | 176 +++++++++++++++++
 1 files changed

// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner with a shadow register that
// takes new data only at frame boundaries, plus leading-zero blanking and an "Err" mode.
module seg_scan_ctrl #(
   parameter int DIV = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        load,
   input  logic [15:0] value,
   input  logic        err,
   input  logic        clr,
   output logic        ready,
   output logic [7:0]  seg,
   output logic [3:0]  dig_en
);

   localparam int CW = $clog2(DIV);
   localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

   typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

   state_t        state_r, state_s;
   logic [CW-1:0] cnt_r, cnt_s;
   logic [1:0]    dig_r, dig_s;
   logic [15:0]   act_val_r, act_val_s, shd_val_r, shd_val_s;
   logic          act_err_r, act_err_s, shd_err_r, shd_err_s;
   logic          pend_r, pend_s, ready_r, ready_s;
   logic          frame_end_s;
   logic [7:0]    seg_s;
   logic [3:0]    dig_en_s;
   logic [3:0]    nib_s;
   logic          blank_s;

   function automatic logic [7:0] digit_pattern(input logic [3:0] nib);
      case (nib)
         4'd0:    digit_pattern = 8'b0111_1110;
         4'd1:    digit_pattern = 8'b0011_0000;
         4'd2:    digit_pattern = 8'b0110_1101;
         4'd3:    digit_pattern = 8'b0111_1001;
         4'd4:    digit_pattern = 8'b0011_0011;
         4'd5:    digit_pattern = 8'b0101_1011;
         4'd6:    digit_pattern = 8'b0101_1111;
         4'd7:    digit_pattern = 8'b0111_0000;
         4'd8:    digit_pattern = 8'b0111_1111;
         4'd9:    digit_pattern = 8'b0111_1011;
         default: digit_pattern = 8'b0100_1111;
      endcase
   endfunction

   // State register and all datapath registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r   <= IDLE;
         cnt_r     <= {CW{1'b0}};
         dig_r     <= 2'd0;
         act_val_r <= 16'h0000;
         act_err_r <= 1'b0;
         shd_val_r <= 16'h0000;
         shd_err_r <= 1'b0;
         pend_r    <= 1'b0;
         ready_r   <= 1'b1;
      end else begin
         state_r   <= state_s;
         cnt_r     <= cnt_s;
         dig_r     <= dig_s;
         act_val_r <= act_val_s;
         act_err_r <= act_err_s;
         shd_val_r <= shd_val_s;
         shd_err_r <= shd_err_s;
         pend_r    <= pend_s;
         ready_r   <= ready_s;
      end
   end

   // Next-state: scan timing, shadow capture and frame-boundary commit.
   always_comb begin
      state_s     = state_r;
      cnt_s       = cnt_r;
      dig_s       = dig_r;
      act_val_s   = act_val_r;
      act_err_s   = act_err_r;
      shd_val_s   = shd_val_r;
      shd_err_s   = shd_err_r;
      pend_s      = pend_r;
      ready_s     = ready_r;
      frame_end_s = (state_r == SCAN) && (dig_r == 2'd3) && (cnt_r == CNT_MAX);
      if (clr) begin
         state_s   = IDLE;
         cnt_s     = {CW{1'b0}};
         dig_s     = 2'd0;
         act_val_s = 16'h0000;
         act_err_s = 1'b0;
         pend_s    = 1'b0;
         ready_s   = 1'b1;
      end else begin
         case (state_r)
            IDLE: begin
               if (pend_r) begin
                  act_val_s = shd_val_r;
                  act_err_s = shd_err_r;
                  pend_s    = 1'b0;
                  ready_s   = 1'b1;
                  state_s   = SCAN;
                  cnt_s     = {CW{1'b0}};
                  dig_s     = 2'd0;
               end else begin
                  state_s = IDLE;
               end
            end
            SCAN: begin
               if (cnt_r == CNT_MAX) begin
                  cnt_s = {CW{1'b0}};
                  dig_s = dig_r + 2'd1;
               end else begin
                  cnt_s = cnt_r + CW'(1);
               end
               if (frame_end_s && pend_r) begin
                  act_val_s = shd_val_r;
                  act_err_s = shd_err_r;
                  pend_s    = 1'b0;
                  ready_s   = 1'b1;
               end else begin
                  pend_s = pend_r;
               end
            end
            default: state_s = IDLE;
         endcase
         // ready=1 implies nothing is pending, so this never collides with a commit.
         if (load && ready_r) begin
            shd_val_s = value;
            shd_err_s = err;
            pend_s    = 1'b1;
            ready_s   = 1'b0;
         end else begin
            shd_val_s = shd_val_s;
         end
      end
   end

   // Output decode from registered state only; cnt=0 is a dark guard slot.
   always_comb begin
      seg_s    = 8'h00;
      dig_en_s = 4'b0000;
      nib_s    = act_val_r[{dig_r, 2'b00} +: 4];
      case (dig_r)
         2'd0:    blank_s = 1'b0;
         2'd1:    blank_s = (act_val_r[15:4] == 12'h000);
         2'd2:    blank_s = (act_val_r[15:8] == 8'h00);
         2'd3:    blank_s = (act_val_r[15:12] == 4'h0);
         default: blank_s = 1'b0;
      endcase
      if ((state_r == SCAN) && (cnt_r != {CW{1'b0}})) begin
         dig_en_s = 4'b0001 << dig_r;
         if (act_err_r) begin
            case (dig_r)
               2'd3:    seg_s = 8'b0100_1111;
               2'd2:    seg_s = 8'b0000_0101;
               2'd1:    seg_s = 8'b0000_0101;
               default: seg_s = 8'b0000_0000;
            endcase
         end else if (blank_s) begin
            seg_s = 8'h00;
         end else begin
            seg_s = digit_pattern(nib_s);
         end
      end else begin
         seg_s    = 8'h00;
         dig_en_s = 4'b0000;
      end
   end

   assign ready  = ready_r;
   assign seg    = seg_s;
   assign dig_en = dig_en_s;

endmodule
